// File: rtl/data_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | data_mem_responder: MA-stage data memory with registered response and a     |
// | low-priority debug word read port.                       Revision: 1.0     |
// +----------------------------------------------------------------------------+
module data_mem_responder #(
  parameter int NB_DATA         = 32,
  parameter int N_DATA_MEM_ADDR = 64,
  parameter int NB_ADDR_MEM     = $clog2(N_DATA_MEM_ADDR),
  parameter int NB_DBG_ADDR     = NB_ADDR_MEM - 2
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic                   i_req_write,
  input  logic [NB_ADDR_MEM-1:0] i_req_addr,
  input  logic [1:0]             i_req_addressing,
  input  logic                   i_req_signing,
  input  logic [NB_DATA-1:0]     i_req_wdata,
  output logic                   o_rsp_valid,
  input  logic                   i_rsp_ready,
  output logic [NB_DATA-1:0]     o_rsp_rdata,
  output logic                   o_rsp_err,
  input  logic                   i_dbg_rd_valid,
  input  logic [NB_DBG_ADDR-1:0] i_dbg_addr,
  output logic                   o_dbg_rd_valid,
  output logic [NB_DATA-1:0]     o_dbg_rd_data
);

  localparam int c_N_WORDS = N_DATA_MEM_ADDR / 4;
  localparam int c_N_LANES = NB_DATA / 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [NB_DATA-1:0]     r_mem [c_N_WORDS];
  logic                   r_dbg_pending;

  logic                   w_accept;
  logic                   w_err;
  logic                   w_store;
  logic                   w_dbg_req;
  logic                   w_dbg_serve;
  logic [NB_ADDR_MEM-3:0] w_word_idx;
  logic [1:0]             w_lane;
  logic [NB_DATA-1:0]     w_rd_word;
  logic [7:0]             w_rd_byte;
  logic [15:0]            w_rd_half;
  logic [NB_DATA-1:0]     w_load_data;
  logic [NB_DATA-1:0]     w_wr_data;
  logic [c_N_LANES-1:0]   w_wr_mask;

  assign o_req_ready = !o_rsp_valid || i_rsp_ready;
  assign w_accept    = i_req_valid && o_req_ready;
  assign w_word_idx  = i_req_addr[NB_ADDR_MEM-1:2];
  assign w_lane      = i_req_addr[1:0];
  assign w_store     = w_accept && i_req_write && !w_err;

  always_comb begin
    w_err = 1'b0;
    case (i_req_addressing)
      2'b01:   w_err = w_lane[0];
      2'b11:   w_err = |w_lane;
      2'b10:   w_err = 1'b1;
      default: w_err = 1'b0;
    endcase
  end

  // Halfword lane select only needs lane[1]; odd lanes are already errors.
  assign w_rd_word = r_mem[w_word_idx];
  assign w_rd_byte = w_rd_word[{w_lane, 3'b000} +: 8];
  assign w_rd_half = w_rd_word[{w_lane[1], 4'b0000} +: 16];

  always_comb begin
    w_load_data = w_rd_word;
    w_wr_data   = i_req_wdata;
    w_wr_mask   = '1;
    case (i_req_addressing)
      2'b00: begin
        w_load_data = {{(NB_DATA-8){i_req_signing & w_rd_byte[7]}}, w_rd_byte};
        w_wr_data   = {c_N_LANES{i_req_wdata[7:0]}};
        w_wr_mask   = c_N_LANES'(1) << w_lane;
      end
      2'b01: begin
        w_load_data = {{(NB_DATA-16){i_req_signing & w_rd_half[15]}}, w_rd_half};
        w_wr_data   = {(c_N_LANES/2){i_req_wdata[15:0]}};
        w_wr_mask   = c_N_LANES'(3) << w_lane;
      end
      2'b10: w_wr_mask = '0;
      default: begin
        w_load_data = w_rd_word;
        w_wr_data   = i_req_wdata;
        w_wr_mask   = '1;
      end
    endcase
  end

  // Array is intentionally outside the reset domain.
  always_ff @(posedge i_clk) begin
    if (w_store) begin
      for (int l = 0; l < c_N_LANES; l++) begin
        if (w_wr_mask[l]) begin
          r_mem[w_word_idx][l*8 +: 8] <= w_wr_data[l*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = HOLD;
      HOLD:    if (i_rsp_ready && !w_accept) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign o_rsp_valid = (r_state == HOLD);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_rsp_rdata <= '0;
      o_rsp_err   <= 1'b0;
    end else if (w_accept) begin
      o_rsp_err   <= w_err;
      o_rsp_rdata <= (w_err || i_req_write) ? '0 : w_load_data;
    end
  end

  // A debug request blocked by an MA acceptance stays pending until a free cycle.
  assign w_dbg_req   = i_dbg_rd_valid || r_dbg_pending;
  assign w_dbg_serve = w_dbg_req && !w_accept;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_dbg_pending  <= 1'b0;
      o_dbg_rd_valid <= 1'b0;
      o_dbg_rd_data  <= '0;
    end else begin
      r_dbg_pending  <= w_dbg_req && w_accept;
      o_dbg_rd_valid <= w_dbg_serve;
      if (w_dbg_serve) begin
        o_dbg_rd_data <= r_mem[i_dbg_addr];
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder side of the memory-access-stage data memory interface.
- Accepts byte/halfword/word load and store requests from the MA stage over a valid/ready handshake and performs the access on a byte-addressed, little-endian word array.
- Returns load data, sign- or zero-extended, with a registered response and backpressure.
- A low-priority debug read port lets the debug unit dump memory words in idle cycles.

Parameters:
- NB_DATA, 32, data width in bits.
- N_DATA_MEM_ADDR, 64, memory size in bytes (multiple of 4).
- NB_ADDR_MEM, $clog2(N_DATA_MEM_ADDR), byte address width.
- NB_DBG_ADDR, NB_ADDR_MEM-2, debug word-index width.

Ports:
- i_clk  in  1  clock, all state on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  request accepted this cycle when high together with i_req_valid.
- i_req_write  in  1  1 = store, 0 = load.
- i_req_addr  in  NB_ADDR_MEM  byte address.
- i_req_addressing  in  2  00 byte, 01 halfword, 11 word; 10 reserved.
- i_req_signing  in  1  1 = sign-extend loads, 0 = zero-extend.
- i_req_wdata  in  NB_DATA  store data; low bytes used for byte/half.
- o_rsp_valid  out  1  response present.
- i_rsp_ready  in  1  consumer takes response.
- o_rsp_rdata  out  NB_DATA  extended load data; 0 for stores and errors.
- o_rsp_err  out  1  misaligned or reserved-size request.
- i_dbg_rd_valid  in  1  debug read request.
- i_dbg_addr  in  NB_DBG_ADDR  word index.
- o_dbg_rd_valid  out  1  debug data valid, 1-cycle pulse.
- o_dbg_rd_data  out  NB_DATA  full word at the debug index.

Behaviour:
- Reset:
  - Asynchronous, active-high.
  - o_rsp_valid=0, o_rsp_err=0, o_rsp_rdata=0, o_dbg_rd_valid=0, o_dbg_rd_data=0, FSM=IDLE.
  - Memory array contents are not altered by reset.
  - Reset mid-operation drops any pending response and any pending debug read.
- Readiness: o_req_ready = !o_rsp_valid || i_rsp_ready (combinational). Single response slot, no additional buffering.
- FSM states:
  - IDLE: no response held.
  - HOLD: response held, waiting for i_rsp_ready.
- FSM transitions:
  - IDLE, on acceptance -> HOLD.
  - HOLD, with i_rsp_ready and new acceptance -> HOLD (slot reloaded).
  - HOLD, with i_rsp_ready and no acceptance -> IDLE.
  - HOLD, with !i_rsp_ready -> HOLD; response held stable.
- Latency: request accepted at edge N gives o_rsp_valid high after edge N. Back-to-back throughput is one request per cycle while i_rsp_ready=1.
- Alignment:
  - Halfword requires addr[0]=0; word requires addr[1:0]=00; addressing 10 is always an error.
  - On error: no memory write, o_rsp_err=1, o_rsp_rdata=0.
- Stores:
  - Byte lanes are written at the acceptance edge, per the size and addr[1:0].
  - Byte writes wdata[7:0] to lane addr[1:0]; halfword writes wdata[15:0] to lanes addr[1:0] and addr[1:0]+1.
  - Response carries rdata=0, err=0.
- Loads:
  - The addressed bytes are extracted little-endian from the word at addr[NB_ADDR_MEM-1:2] and extended per i_req_signing.
  - A load accepted in the cycle after a store to the same address returns the stored data; no read-during-write hazard across consecutive accepted requests.
- Debug port:
  - Served only in a cycle with no request acceptance (i_req_valid=0 or o_req_ready=0); the MA stage always has priority.
  - A debug request arriving while blocked is latched once and served in the first free cycle; further requests during the wait are ignored.
  - o_dbg_rd_valid pulses one cycle after service, with o_dbg_rd_data = word at i_dbg_addr as sampled at service time.
- Address wrap: addresses beyond the array are impossible by construction of the width; no wrap logic is needed.

Test Plan:
- Store word 0xDEADBEEF at addr 8, then load word at 8 -> rsp_valid one cycle after each acceptance; rdata=0xDEADBEEF, err=0.
- Load byte at addr 11 (value 0xDE): signing=1 -> rdata=0xFFFFFFDE; signing=0 -> 0x000000DE. Load half at addr 8: signing=1 -> 0xFFFFBEEF; signing=0 -> 0x0000BEEF.
- Store half 0x1234 at addr 9 -> err=1, memory at word 8 unchanged (later load word = 0xDEADBEEF). Addressing 10 at addr 0 -> err=1.
- Hold i_rsp_ready=0 for 3 cycles after a load -> o_req_ready=0, rsp fields stable. Release with a new request waiting -> accepted in the same cycle; next response follows one cycle later.
- Debug read of word index 2 while the MA stage issues 4 back-to-back requests -> debug served in the first idle cycle; o_dbg_rd_data=0xDEADBEEF, single-cycle pulse.
- Assert i_reset while in HOLD -> o_rsp_valid=0 immediately (asynchronous); after release, the memory still holds 0xDEADBEEF at addr 8.
